// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: FSM state encoding and owner codes.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_LS = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_select.sv
// Winner selection between IF and LS. LS has priority, but an LS burst counter
// hands the port to a waiting IF after MAX_LS_BURST consecutive LS grants.
module mem_arb_select #(
  parameter int MAX_LS_BURST = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic ls_req,
  input  logic arb_en,
  output logic grant_valid,
  output logic grant_ls
);

  localparam int BW = $clog2(MAX_LS_BURST + 1);

  logic [BW-1:0] ls_burst_q;
  logic [BW-1:0] ls_burst_d;
  logic          burst_full;

  assign burst_full = (ls_burst_q == BW'(MAX_LS_BURST));

  always_comb begin
    grant_valid = arb_en & (if_req | ls_req);
    grant_ls    = grant_valid & ls_req & (~if_req | ~burst_full);
    ls_burst_d  = ls_burst_q;
    if (arb_en) begin
      // Only LS wins that actually made IF wait count towards the burst.
      if (!if_req) begin
        ls_burst_d = '0;
      end else if (grant_valid && !grant_ls) begin
        ls_burst_d = '0;
      end else if (grant_ls && !burst_full) begin
        ls_burst_d = ls_burst_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ls_burst_q <= '0;
    end else begin
      ls_burst_q <= ls_burst_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous single-port memory between instruction fetch and
// load/store: arbitrate, hold the access for WAIT_CYCLES, capture data, ack.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int WAIT_CYCLES  = 1,
  parameter int MAX_LS_BURST = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_ack,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [DATA_W/8-1:0] ls_be,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                ls_ack,
  output logic                mem_en,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy,
  output logic                owner
);

  localparam int WW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  state_e                state_q, state_d;
  logic [WW-1:0]         wait_q, wait_d;
  logic                  owner_q, owner_d;
  logic                  store_q, store_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W/8-1:0]   be_q, be_d;
  logic [DATA_W-1:0]     if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]     ls_rdata_q, ls_rdata_d;
  logic                  grant_valid;
  logic                  grant_ls;

  mem_arb_select #(
    .MAX_LS_BURST(MAX_LS_BURST)
  ) u_select (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .ls_req     (ls_req),
    .arb_en     (state_q == ST_IDLE),
    .grant_valid(grant_valid),
    .grant_ls   (grant_ls)
  );

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    owner_d    = owner_q;
    store_d    = store_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    if_rdata_d = if_rdata_q;
    ls_rdata_d = ls_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          state_d = ST_ACCESS;
          owner_d = grant_ls ? OWN_LS : OWN_IF;
          store_d = grant_ls & ls_we;
          addr_d  = grant_ls ? ls_addr : if_addr;
          wdata_d = grant_ls ? ls_wdata : '0;
          be_d    = grant_ls ? ls_be : '0;
          wait_d  = WW'(WAIT_CYCLES - 1);
        end
      end
      ST_ACCESS: begin
        if (wait_q == '0) begin
          // Stores never disturb either requester's last read data.
          if (!store_q) begin
            if (owner_q == OWN_LS) ls_rdata_d = mem_rdata;
            else                   if_rdata_d = mem_rdata;
          end
          state_d = ST_RESP;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wait_q     <= '0;
      owner_q    <= OWN_IF;
      store_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      owner_q    <= owner_d;
      store_q    <= store_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      if_rdata_q <= if_rdata_d;
      ls_rdata_q <= ls_rdata_d;
    end
  end

  assign mem_en    = (state_q == ST_ACCESS);
  assign mem_we    = (mem_en && store_q) ? be_q : '0;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_ack    = (state_q == ST_RESP) && (owner_q == OWN_IF);
  assign ls_ack    = (state_q == ST_RESP) && (owner_q == OWN_LS);
  assign if_rdata  = if_rdata_q;
  assign ls_rdata  = ls_rdata_q;
  assign busy      = (state_q != ST_IDLE);
  assign owner     = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a WAIT_CYCLES=1 instance with a byte-lane memory
// model and an ack scoreboard, plus a WAIT_CYCLES=3 instance for latency checks.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;

  logic        if_req, ls_req, ls_we;
  logic [31:0] if_addr, ls_addr, ls_wdata, if_rdata, ls_rdata;
  logic [3:0]  ls_be, mem_we;
  logic        if_ack, ls_ack, mem_en, busy, owner;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic        b_if_req, b_ls_req, b_ls_we;
  logic [31:0] b_if_addr, b_ls_addr, b_ls_wdata, b_if_rdata, b_ls_rdata;
  logic [3:0]  b_ls_be, b_mem_we;
  logic        b_if_ack, b_ls_ack, b_mem_en, b_busy, b_owner;
  logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

  int          total;
  int          bad;
  logic [32:0] exp_q[$];
  logic [32:0] mon_act, mon_exp;
  logic [31:0] mem [0:63];

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(1), .MAX_LS_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .ls_req(ls_req), .ls_we(ls_we), .ls_be(ls_be), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_rdata(ls_rdata), .ls_ack(ls_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(3), .MAX_LS_BURST(4)) dut3 (
    .clk(clk), .rst(rst),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata), .if_ack(b_if_ack),
    .ls_req(b_ls_req), .ls_we(b_ls_we), .ls_be(b_ls_be), .ls_addr(b_ls_addr),
    .ls_wdata(b_ls_wdata), .ls_rdata(b_ls_rdata), .ls_ack(b_ls_ack),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .busy(b_busy), .owner(b_owner)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: combinational read, byte-lane write, preload while in reset.
  assign mem_rdata   = mem[mem_addr[7:2]];
  assign b_mem_rdata = (b_mem_addr == 32'h40) ? 32'hCAFEF00D :
                       (b_mem_addr == 32'h44) ? 32'h11111111 : 32'h0;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[4]  <= 32'hE3A01005;
      mem[12] <= 32'h12345678;
    end else if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) mem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  // Scoreboard monitor: entries are {is_ls, rdata}
  always @(negedge clk) begin
    if (!rst && (if_ack || ls_ack)) begin
      mon_act = if_ack ? {1'b0, if_rdata} : {1'b1, ls_rdata};
      total++;
      if (if_ack && ls_ack) begin
        bad++;
        $display("FAIL ack_overlap: got if_ack=1 ls_ack=1 expected one ack");
      end else if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_ack: got %h expected no ack", mon_act);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act !== mon_exp) begin
          bad++;
          $display("FAIL ack_data: got %h expected %h", mon_act, mon_exp);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Driver tasks: issue one request from IDLE and wait (bounded) for its ack.
  task automatic run_if(input logic [31:0] addr, input logic [31:0] exp_data);
    int  n;
    bit  done;
    @(negedge clk);
    if_req  = 1'b1;
    if_addr = addr;
    exp_q.push_back({1'b0, exp_data});
    n    = 0;
    done = 1'b0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        check("if_mem_en_c1", mem_en, 1);
        check("if_mem_addr", mem_addr, addr);
      end
      if (if_ack) done = 1'b1;
    end
    if_req = 1'b0;
    check("if_ack_latency", n, 2);
  endtask

  task automatic run_ls(input logic we, input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_data);
    int  n;
    bit  done;
    @(negedge clk);
    ls_req   = 1'b1;
    ls_we    = we;
    ls_be    = be;
    ls_addr  = addr;
    ls_wdata = wdata;
    exp_q.push_back({1'b1, exp_data});
    n    = 0;
    done = 1'b0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        check("ls_mem_we", mem_we, we ? be : 4'h0);
        check("ls_mem_addr", mem_addr, addr);
      end
      if (ls_ack) done = 1'b1;
    end
    ls_req = 1'b0;
    check("ls_ack_latency", n, 2);
  endtask

  initial begin
    int acks, gap, guard;
    total = 0;
    bad   = 0;
    rst = 1'b1;
    if_req = 0; if_addr = 0; ls_req = 0; ls_we = 0; ls_be = 0; ls_addr = 0; ls_wdata = 0;
    b_if_req = 0; b_if_addr = 0; b_ls_req = 0; b_ls_we = 0; b_ls_be = 0; b_ls_addr = 0;
    b_ls_wdata = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Idle after reset: everything stays zero
    repeat (10) begin
      @(negedge clk);
      check("idle_ctl", {busy, mem_en, mem_we, if_ack, ls_ack, owner}, 0);
      check("idle_bus", {mem_addr, mem_wdata}, 0);
    end
    check("idle_rdata", {if_rdata, ls_rdata}, 0);

    // Fetch
    run_if(32'h10, 32'hE3A01005);
    check("owner_if", owner, 0);

    // Partial store, load-back, and zero-byte-enable store
    run_ls(1'b1, 4'b0011, 32'h20, 32'hDEADBEEF, 32'h0);
    run_ls(1'b0, 4'b0000, 32'h20, 32'h0, 32'h0000BEEF);
    check("if_rdata_kept", if_rdata, 32'hE3A01005);
    check("owner_ls", owner, 1);
    run_ls(1'b1, 4'b0000, 32'h24, 32'hFFFFFFFF, 32'h0000BEEF);
    run_ls(1'b0, 4'b0000, 32'h24, 32'h0, 32'h0);

    // Contention: LS x4 then IF, repeating
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h10;
    ls_req = 1'b1; ls_we = 1'b0; ls_be = 4'h0; ls_addr = 32'h30;
    for (int i = 0; i < 20; i++)
      exp_q.push_back((i % 5 == 4) ? {1'b0, 32'hE3A01005} : {1'b1, 32'h12345678});
    acks = 0; gap = 0; guard = 0;
    while (acks < 20 && guard < 200) begin
      @(negedge clk);
      guard++;
      gap++;
      if (if_ack || ls_ack) begin
        acks++;
        if (acks > 1) check("ack_spacing", gap, 3);
        gap = 0;
      end
    end
    if_req = 1'b0;
    ls_req = 1'b0;
    check("burst_ack_count", acks, 20);
    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    // WAIT_CYCLES=3 load; address change mid-access must be ignored
    @(negedge clk);
    b_ls_req = 1'b1; b_ls_we = 1'b0; b_ls_addr = 32'h40;
    for (int n = 1; n <= 3; n++) begin
      @(negedge clk);
      check("w3_mem_en", b_mem_en, 1);
      check("w3_mem_addr", b_mem_addr, 32'h40);
      check("w3_no_early_ack", b_ls_ack, 0);
      if (n == 1) b_ls_addr = 32'h44;
    end
    @(negedge clk);
    check("w3_mem_en_off", b_mem_en, 0);
    check("w3_ack", b_ls_ack, 1);
    check("w3_rdata", b_ls_rdata, 32'hCAFEF00D);
    b_ls_req = 1'b0;
    @(negedge clk);
    check("w3_ack_pulse", b_ls_ack, 0);

    // Reset in the ACCESS cycle of a fetch
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h10;
    @(negedge clk);
    check("rst_pre_access", mem_en, 1);
    rst = 1'b1;
    #1;
    check("rst_ctl", {busy, mem_en, mem_we, if_ack, ls_ack, owner}, 0);
    check("rst_rdata", {if_rdata, ls_rdata}, 0);
    if_req = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rst_no_ack", if_ack, 0);
    end
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("post_rst_idle", {busy, if_ack}, 0);
    end
    run_if(32'h10, 32'hE3A01005);
    repeat (2) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
